// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Multi-cycle datapath ALU. Single-cycle logic/add/shift ops plus
//             sequential signed multiply (shift-add) and signed divide
//             (restoring), one bit per clock, with a start/busy/done handshake.
//             The divider is built only when the macro ALU_DIV_EN is defined;
//             without it, op 12 is reported as illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] RY,
    input  logic [WIDTH-1:0] BUSin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ZLO,
    output logic [WIDTH-1:0] ZHI,
    output logic             dz,
    output logic             ill
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHRA = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);
    localparam logic [SHW:0] CNT_DZ   = (SHW+1)'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;       // raw latched operands
    logic [WIDTH-1:0] m_q;            // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, lo_q;     // product or {remainder, quotient}
    logic [SHW:0]     cnt_q;
    logic             neg_lo_q;       // negate product / quotient in FIX
    logic             dz_pend_q;      // divide-by-zero detected at accept

    logic             w_div_in, w_div_q, w_seq_in, w_seq_q, w_dz_in, w_ill_q;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_alu;
    logic [SHW-1:0]   w_n;
    logic [2*WIDTH-1:0] w_dbl, w_ror2, w_rol2, w_prod_neg;
    logic [WIDTH:0]   w_sum;

`ifdef ALU_DIV_EN
    logic             neg_hi_q;       // remainder takes the sign of RY
    logic [WIDTH:0]   w_rs, w_diff;
    assign w_div_in = (op == OP_DIV);
    assign w_div_q  = (op_q == OP_DIV);
    assign w_rs     = {hi_q, lo_q[WIDTH-1]};
    assign w_diff   = w_rs - {1'b0, m_q};
`else
    assign w_div_in = 1'b0;
    assign w_div_q  = 1'b0;
`endif

    assign w_seq_in   = (op == OP_MUL) || w_div_in;
    assign w_seq_q    = (op_q == OP_MUL) || w_div_q;
    assign w_dz_in    = w_div_in && (BUSin == '0);
    assign w_ill_q    = !((op_q <= OP_MUL) || w_div_q);
    assign w_mag_a    = RY[WIDTH-1]    ? -RY    : RY;
    assign w_mag_b    = BUSin[WIDTH-1] ? -BUSin : BUSin;
    assign w_n        = b_q[SHW-1:0];
    assign w_dbl      = {a_q, a_q};
    assign w_ror2     = w_dbl >> w_n;
    assign w_rol2     = w_dbl << w_n;
    assign w_prod_neg = -{hi_q, lo_q};
    assign w_sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

    // Single-cycle result computed from the latched operands
    always_comb begin
        w_alu = '0;
        case (op_q)
            OP_ADD:  w_alu = a_q + b_q;
            OP_SUB:  w_alu = a_q - b_q;
            OP_AND:  w_alu = a_q & b_q;
            OP_OR:   w_alu = a_q | b_q;
            OP_NOT:  w_alu = ~b_q;
            OP_NEG:  w_alu = -b_q;
            OP_SHR:  w_alu = a_q >> w_n;
            OP_SHRA: w_alu = $signed(a_q) >>> w_n;
            OP_SHL:  w_alu = a_q << w_n;
            OP_ROR:  w_alu = w_ror2[WIDTH-1:0];
            OP_ROL:  w_alu = w_rol2[2*WIDTH-1:WIDTH];
            default: w_alu = '0;
        endcase
    end

    // Next-state logic; divide-by-zero idles in FIX to keep the MUL/DIV latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = w_seq_in ? (w_dz_in ? S_FIX : S_ITER) : S_DONE;
            S_ITER: if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:  if (!dz_pend_q || (cnt_q == CNT_DZ)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_lo_q  <= 1'b0;
            dz_pend_q <= 1'b0;
`ifdef ALU_DIV_EN
            neg_hi_q  <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            ZLO       <= '0;
            ZHI       <= '0;
            dz        <= 1'b0;
            ill       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        a_q       <= RY;
                        b_q       <= BUSin;
                        busy      <= 1'b1;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        neg_lo_q  <= RY[WIDTH-1] ^ BUSin[WIDTH-1];
                        dz_pend_q <= w_dz_in;
`ifdef ALU_DIV_EN
                        neg_hi_q  <= RY[WIDTH-1];
`endif
                        // MUL shifts the multiplier out of lo; DIV shifts the dividend
                        if (op == OP_MUL) begin
                            lo_q <= w_mag_b;
                            m_q  <= w_mag_a;
                        end else begin
                            lo_q <= w_mag_a;
                            m_q  <= w_mag_b;
                        end
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + CNT_ONE;
`ifdef ALU_DIV_EN
                    if (op_q == OP_DIV) begin
                        if (!w_diff[WIDTH]) begin
                            hi_q <= w_diff[WIDTH-1:0];
                            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_q <= w_rs[WIDTH-1:0];
                            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        hi_q <= w_sum[WIDTH:1];
                        lo_q <= {w_sum[0], lo_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
`ifdef ALU_DIV_EN
                    if (dz_pend_q) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        lo_q  <= '1;
                        hi_q  <= a_q;
                    end else if (op_q == OP_DIV) begin
                        if (neg_lo_q) lo_q <= -lo_q;
                        if (neg_hi_q) hi_q <= -hi_q;
                    end else
`endif
                    begin
                        if (neg_lo_q) {hi_q, lo_q} <= w_prod_neg;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (w_seq_q) begin
                        ZLO <= lo_q;
                        ZHI <= hi_q;
                        dz  <= dz_pend_q;
                        ill <= 1'b0;
                    end else begin
                        ZLO <= w_ill_q ? '0 : w_alu;
                        ZHI <= '0;
                        dz  <= 1'b0;
                        ill <= w_ill_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Scoreboard bench for alu_seq (WIDTH=32). Expected results come
//             from a behavioural model and are queued at issue time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] RY, BUSin;
    logic        busy, done, dz, ill;
    logic [31:0] ZLO, ZHI;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    alu_seq #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op),
        .RY(RY), .BUSin(BUSin), .busy(busy), .done(done),
        .ZLO(ZLO), .ZHI(ZHI), .dz(dz), .ill(ill)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, p, q, r;
        int          n;
        logic [31:0] rr;
        e.lo = '0; e.hi = '0; e.dz = 1'b0; e.ill = 1'b0; e.lat = 1;
        n  = int'(b[4:0]);
        sa = $signed(a);
        sb = $signed(b);
        rr = '0;
        case (o)
            4'd0:  e.lo = a + b;
            4'd1:  e.lo = a - b;
            4'd2:  e.lo = a & b;
            4'd3:  e.lo = a | b;
            4'd4:  e.lo = ~b;
            4'd5:  e.lo = 32'd0 - b;
            4'd6:  e.lo = a >> n;
            4'd7:  begin p = sa >>> n; e.lo = p[31:0]; end
            4'd8:  e.lo = a << n;
            4'd9:  begin for (int i = 0; i < 32; i++) rr[i] = a[(i + n) % 32]; e.lo = rr; end
            4'd10: begin for (int i = 0; i < 32; i++) rr[i] = a[(i - n + 32) % 32]; e.lo = rr; end
            4'd11: begin p = sa * sb; e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 34; end
            4'd12: begin
`ifdef ALU_DIV_EN
                e.lat = 34;
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
`else
                e.ill = 1'b1;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Issue one op, wait for done (bounded), compare with the scoreboard head
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse);
        exp_t e;
        int   lat, busy_cnt, extra;
        bit   got;
        @(negedge clock);
        start = 1'b1; op = o; RY = a; BUSin = b;
        sb_q.push_back(model(o, a, b));
        @(posedge clock); #1;
        start = 1'b0; op = 4'($urandom); RY = $urandom; BUSin = $urandom;
        check({tag, "_busy_acc"}, busy, 1);
        lat = 0; busy_cnt = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
            if (pulse && !got) begin
                start = (lat < 30) ? lat[0] : (lat == 33);
                op    = 4'($urandom);
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_done"}, got, 1);
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_busycnt"}, busy_cnt, e.lat - 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_lo"}, ZLO, e.lo);
        check({tag, "_hi"}, ZHI, e.hi);
        check({tag, "_dz"}, dz, e.dz);
        check({tag, "_ill"}, ill, e.ill);
        extra = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (done) extra++;
        end
        check({tag, "_extra_done"}, extra, 0);
        check({tag, "_hold_lo"}, ZLO, e.lo);
    endtask

    initial begin
        int dn;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        clear = 1'b0; start = 1'b0; op = '0; RY = '0; BUSin = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_zlo", ZLO, 0);
        check("rst_zhi", ZHI, 0);
        check("rst_flags", {dz, ill}, 0);
        @(negedge clock); clear = 1'b1;

        // Async clear in the middle of a multiply
        run_op("add_pre", 4'd0, 32'd5, 32'd6, 1'b0);
        @(negedge clock);
        start = 1'b1; op = 4'd11; RY = -32'sd3; BUSin = 32'd7;
        @(posedge clock); #1; start = 1'b0;
        repeat (9) @(posedge clock);
        #3 clear = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_zlo", ZLO, 0);
        check("abort_zhi", ZHI, 0);
        @(negedge clock); clear = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dn++;
        end
        check("abort_nodone", dn, 0);

        run_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd1,         1'b0);
        run_op("sub",      4'd1,  32'd10,        32'd3,         1'b0);
        run_op("sub_neg",  4'd1,  32'd0,         32'd1,         1'b0);
        run_op("and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        run_op("or",       4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 1'b0);
        run_op("not",      4'd4,  32'h1234_5678, 32'h0F0F_0000, 1'b0);
        run_op("neg",      4'd5,  32'd0,         32'd1,         1'b0);
        run_op("shr",      4'd6,  32'h8000_0000, 32'd31,        1'b0);
        run_op("shra",     4'd7,  32'h8000_0010, 32'd4,         1'b0);
        run_op("shl",      4'd8,  32'h0000_0001, 32'd31,        1'b0);
        run_op("ror",      4'd9,  32'h0000_0001, 32'd1,         1'b0);
        run_op("rol",      4'd10, 32'h8000_0001, 32'd1,         1'b0);
        run_op("shl_n0",   4'd8,  32'h1234_5678, 32'h0000_0020, 1'b0);
        run_op("ror_n0",   4'd9,  32'h89AB_CDEF, 32'h0000_0040, 1'b0);
        run_op("mul_m3x7", 4'd11, -32'sd3,       32'd7,         1'b1);
        run_op("mul_minsq",4'd11, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mul_m1sq", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_mix",  4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("div_m7_2", 4'd12, -32'sd7,       32'd2,         1'b0);
        run_op("div_7_m2", 4'd12, 32'd7,         -32'sd2,       1'b0);
        run_op("div_zero", 4'd12, 32'd5,         32'd0,         1'b0);
        run_op("div_ovf",  4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("ill13",    4'd13, 32'd1,         32'd2,         1'b0);
        run_op("ill14",    4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("ill15",    4'd15, 32'd7,         32'd9,         1'b0);

        for (int k = 0; k < 12; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (k % 4 == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rand%0d", k), ro, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle datapath ALU for the CPU datapath. Takes operand RY and operand BUSin and an opcode, and writes a registered 2*WIDTH result as hi/lo halves.
- Single-cycle logic, add and shift ops complete in one cycle. Signed multiply and signed divide are sequential, iterating one bit per clock.
- Sits between the RY register and the Z (ZHI/ZLO) registers, and is controlled by the control unit through a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; power of 2, minimum 8.
- SHW, $clog2(WIDTH), shift-amount field width taken from BUSin[SHW-1:0].

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  4  opcode, sampled with start.
- RY  in  WIDTH  operand A.
- BUSin  in  WIDTH  operand B, also the shift amount.
- busy  out  1  high from the edge that accepts start until done.
- done  out  1  one-cycle pulse; result valid.
- ZLO  out  WIDTH  result low half.
- ZHI  out  WIDTH  result high half.
- dz  out  1  divide-by-zero flag, valid with done.
- ill  out  1  illegal-opcode flag, valid with done.

Behaviour:
- Reset (clear=0, asynchronous):
  - State becomes IDLE.
  - busy, done, dz, ill, ZLO and ZHI all go to 0.
  - Iteration counters go to 0.
  - Reset mid-operation aborts the op; no done is issued.
- Opcodes. Single-cycle ops write ZHI = 0.
  - 0 ADD: ZLO=RY+BUSin (mod 2^WIDTH).
  - 1 SUB: ZLO=RY-BUSin.
  - 2 AND, 3 OR.
  - 4 NOT: ~BUSin.
  - 5 NEG: -BUSin.
  - 6 SHR: logical right shift of RY by n.
  - 7 SHRA: arithmetic right shift of RY by n.
  - 8 SHL: left shift of RY by n.
  - 9 ROR, 10 ROL: rotate RY by n.
  - For ops 6-10, n = BUSin[SHW-1:0] and n=0 passes RY unchanged.
  - 11 MUL: {ZHI,ZLO} = signed RY * signed BUSin (2*WIDTH-bit product).
  - 12 DIV: ZLO = signed quotient RY/BUSin, truncated toward zero; ZHI = remainder, carrying the sign of RY.
  - 13-15: ZLO=ZHI=0, ill=1.
- States:
  - IDLE: on start=1, latch op and operands and set busy=1. Single-cycle or illegal op goes to DONE; MUL/DIV goes to ITER.
  - ITER: convert operands to magnitudes on entry. Run WIDTH unsigned iterations (shift-add for MUL, restoring subtract for DIV), one per clock, counter 0..WIDTH-1.
  - FIX: apply sign correction, then go to DONE.
  - DONE: register result and flags, done=1 for exactly one cycle, busy=0, then IDLE.
- Latency, counted in rising edges after the edge sampling start:
  - Single-cycle and illegal ops: done at edge 1.
  - MUL/DIV: done at edge WIDTH+2.
- Handshake:
  - start while busy=1 is ignored.
  - start high in the DONE cycle is ignored; a new op is accepted only in IDLE. Back-to-back throughput is therefore one op per 2 cycles for single-cycle ops.
  - RY, BUSin and op may change freely after acceptance.
  - ZLO, ZHI, dz and ill hold their values until the next done or reset.
- Divide by zero (BUSin=0):
  - Skip ITER and go straight to FIX.
  - Result: ZLO = all ones, ZHI = RY, dz=1.
  - Latency stays WIDTH+2.
- Overflow:
  - Most-negative / -1: ZLO = most-negative, ZHI = 0, no flag.
  - ADD/SUB overflow wraps silently.
- dz and ill are 0 for every op other than the conditions above.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: divider datapath is present; op 12 behaves as specified.
- Undefined: divider logic is not built and op 12 is treated as illegal: ZLO=ZHI=0, ill=1, done at edge 1.
- MUL is always present.

Test Plan:
- Reset, single-cycle ops and result hold (WIDTH=32):
  - Assert clear mid-MUL (cycle 10) -> busy/done/ZLO/ZHI drop to 0 immediately; no done follows.
  - Then ADD RY=32'hFFFFFFFF, BUSin=1 -> ZLO=0, ZHI=0, done at edge 1.
  - Hold start low -> ZLO stays 0.
- Shifts and rotates:
  - SHRA RY=32'h80000010, BUSin=4 -> ZLO=32'hF8000001.
  - ROL RY=32'h80000001, BUSin=1 -> ZLO=32'h00000003.
  - SHL with BUSin=32'h00000020 (n=0) -> ZLO=RY.
- MUL:
  - RY=-3, BUSin=7 -> {ZHI,ZLO}=64'hFFFFFFFF_FFFFFFEB; done exactly at edge 34; busy high edges 1-33.
- DIV, with ALU_DIV_EN defined:
  - RY=-7, BUSin=2 -> ZLO=-3, ZHI=-1, dz=0.
  - RY=5, BUSin=0 -> ZLO=32'hFFFFFFFF, ZHI=5, dz=1, done at edge 34.
- Handshake and illegal ops:
  - Pulse start repeatedly during MUL -> ignored; exactly one done.
  - Opcode 14 -> ill=1, ZLO=ZHI=0, done at edge 1.
  - With ALU_DIV_EN undefined, op 12 -> ill=1 at edge 1.
